cc_resp_arbiter: RTL
====================

# cc_resp_arbiter

Response-path arbiter of the cache controller. It merges two 518-bit line sources into the single response FIFO that feeds the serializer: the hit path (data array read) and the miss-fill path (memory refill). It grants one source per cycle with round-robin fairness, registers the winning line into the FIFO write port, and uses the FIFO full and almost-full flags so that no write is ever dropped.

## Interface
Parameters:
- DW, 518, line entry width: 512 data bits plus 6 offset/tag-side bits, passed through unchanged.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- hit_valid_i  in  1  hit path holds a line.
- hit_data_i  in  DW  hit line entry.
- hit_ready_o  out  1  hit line accepted this cycle.
- miss_valid_i  in  1  fill path holds a line.
- miss_data_i  in  DW  fill line entry.
- miss_ready_o  out  1  fill line accepted this cycle.
- fifo_full_i  in  1  response FIFO has 0 free entries.
- fifo_afull_i  in  1  response FIFO has ≤1 free entry; it is also high whenever fifo_full_i is high.
- fifo_wren_o  out  1  registered FIFO write enable.
- fifo_wdata_o  out  DW  registered FIFO write data.

## Operation
- Source rules:
  - A handshake completes on valid && ready.
  - A source must hold its valid and data stable until it sees ready. The block does not check this.
- can_accept = !fifo_full_i && !(fifo_afull_i && fifo_wren_o).
  - The FIFO flags do not yet include the write currently on fifo_wren_o. That write is counted as one entry already used.
  - Reads done by the serializer are not credited. This is deliberately conservative.
- Grant (combinational):
  - Only hit valid: grant HIT.
  - Only miss valid: grant MISS.
  - Both valid: grant the source that is not last_grant.
  - can_accept low: no grant, and both ready outputs are low.
- hit_ready_o = can_accept && grant==HIT.
- miss_ready_o = can_accept && grant==MISS.
- At most one ready output is high in any cycle.
- Round-robin state:
  - last_grant is a 1-bit register, 0 = HIT, 1 = MISS.
  - It updates to the granted source on every completed handshake.
  - It holds its value when there is no handshake.
- Output register, loaded every cycle:
  - fifo_wren_o <= handshake happened.
  - fifo_wdata_o <= data of the granted source when a handshake happens; otherwise it holds its previous value.
- Data passes through unmodified. There is no reordering inside one source.

## Timing
- Reset values: fifo_wren_o = 0, fifo_wdata_o = 0, last_grant = MISS (1). The first tie after reset therefore goes to HIT.
- When rst is asserted mid-operation, the outputs clear immediately. A line that was granted but not yet written is lost; the upstream controller is reset on the same reset.
- Latency: a handshake in cycle t produces fifo_wren_o = 1 with that line in cycle t+1.
- Throughput: one line per cycle while can_accept stays high.
- Under continuous contention the grants alternate HIT, MISS, HIT, and so on.
- FIFO boundaries:
  - fifo_full_i = 1: no accept.
  - fifo_afull_i = 1 with fifo_wren_o = 0: one accept allowed. The next cycle is blocked because fifo_wren_o is then 1.
  - fifo_afull_i = 1 with fifo_wren_o = 1: no accept.
- A source that raises valid in the same cycle that space frees is granted in that cycle; there is no extra bubble.
- ready_o depends combinationally on valid_i and the FIFO flags. No input path is registered.

## Test plan
- Reset, then hit_valid = 1 with data = 518'h1A5 for one cycle, FIFO empty.
  - Required: hit_ready_o = 1 in cycle 0.
  - Required: fifo_wren_o = 1 and fifo_wdata_o = 518'h1A5 in cycle 1.
  - Required: fifo_wren_o = 0 in cycle 2.
- Both sources valid continuously for 6 cycles, FIFO empty.
  - Required grant order: H, M, H, M, H, M.
  - Required: 6 consecutive writes with matching data.
- Only miss valid for 4 cycles.
  - Required: 4 writes, each with miss_data.
  - Then both sources valid: the first tie goes to HIT, because last_grant = MISS.
- fifo_afull_i = 1, fifo_full_i = 0, hit valid.
  - Required: accept in cycle 0 and write in cycle 1.
  - Required: no ready in cycle 1, because wren_o = 1.
  - Then force fifo_full_i = 1: no ready for as long as full stays high.
- fifo_full_i = 1 for 5 cycles with both sources valid.
  - Required: both ready outputs low, no writes, last_grant unchanged.
  - Release full: HIT is granted first, provided last_grant was MISS.
- Assert rst asynchronously between a handshake and the following clock edge.
  - Required: fifo_wren_o = 0 immediately and fifo_wdata_o = 0.
  - After release, the first tie is granted to HIT.

Source files
------------

// File: rtl/cc_resp_arbiter.sv
// Response-path arbiter: round-robin merge of hit and miss-fill lines
// into the registered write port of the response FIFO.
module cc_resp_arbiter #(
   parameter int DW = 518
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hit_valid_i,
   input  logic [DW-1:0] hit_data_i,
   output logic          hit_ready_o,
   input  logic          miss_valid_i,
   input  logic [DW-1:0] miss_data_i,
   output logic          miss_ready_o,
   input  logic          fifo_full_i,
   input  logic          fifo_afull_i,
   output logic          fifo_wren_o,
   output logic [DW-1:0] fifo_wdata_o
);

   // 0 = HIT, 1 = MISS
   logic last_grant;
   logic can_accept;
   logic grant_hit;
   logic grant_miss;
   logic handshake;

   // the write in flight on fifo_wren_o is not yet in the flags
   assign can_accept = !fifo_full_i && !(fifo_afull_i && fifo_wren_o);

   always_comb begin
      grant_hit  = 1'b0;
      grant_miss = 1'b0;
      unique case (1'b1)
         (hit_valid_i && !miss_valid_i): grant_hit  = 1'b1;
         (!hit_valid_i && miss_valid_i): grant_miss = 1'b1;
         (hit_valid_i && miss_valid_i): begin
            grant_hit  = last_grant;
            grant_miss = !last_grant;
         end
         default: ;
      endcase
   end

   assign hit_ready_o  = can_accept && grant_hit;
   assign miss_ready_o = can_accept && grant_miss;
   assign handshake    = hit_ready_o || miss_ready_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_wren_o  <= 1'b0;
         fifo_wdata_o <= '0;
         last_grant   <= 1'b1;
      end else begin
         fifo_wren_o <= handshake;
         if (handshake) begin
            fifo_wdata_o <= hit_ready_o ? hit_data_i : miss_data_i;
            last_grant   <= miss_ready_o;
         end
      end
   end

endmodule
